branch_hazard_forwarding_unit: RTL

//  Decode-stage hazard and forwarding unit for early-resolved branches (beq/bne) in the 5-stage MIPS pipeline.

---
 rtl/branch_hazard_forwarding_unit_if.sv | 42 ++++
 rtl/branch_hazard_forwarding_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/branch_hazard_forwarding_unit_if.sv
// Bundles the ID-stage instruction fields, the pipeline-register destination info
// and the hazard/forwarding controls of branch_hazard_forwarding_unit.
interface branch_hazard_forwarding_unit_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int OP_W    = 6,
  parameter int CNT_W   = 16
);
  logic                      idValid;
  logic [OP_W-1:0]           idOp;
  logic [NUM_SRC*ADDR_W-1:0] idSrcRegs;
  logic                      idexRegWrite;
  logic                      idexMemRead;
  logic [ADDR_W-1:0]         idexWriteReg;
  logic                      exmeRegWrite;
  logic                      exmeMemRead;
  logic [ADDR_W-1:0]         exmeWriteReg;
  logic                      mewbRegWrite;
  logic [ADDR_W-1:0]         mewbWriteReg;
  logic [2*NUM_SRC-1:0]      fwdSel;
  logic                      stall;
  logic                      pcWrite;
  logic                      ifidWrite;
  logic                      idexFlush;
  logic [CNT_W-1:0]          stallCycles;

  modport master (
    output idValid, idOp, idSrcRegs,
    output idexRegWrite, idexMemRead, idexWriteReg,
    output exmeRegWrite, exmeMemRead, exmeWriteReg,
    output mewbRegWrite, mewbWriteReg,
    input  fwdSel, stall, pcWrite, ifidWrite, idexFlush, stallCycles
  );

  modport slave (
    input  idValid, idOp, idSrcRegs,
    input  idexRegWrite, idexMemRead, idexWriteReg,
    input  exmeRegWrite, exmeMemRead, exmeWriteReg,
    input  mewbRegWrite, mewbWriteReg,
    output fwdSel, stall, pcWrite, ifidWrite, idexFlush, stallCycles
  );
endinterface

// File: rtl/branch_hazard_forwarding_unit.sv
// ID-stage hazard detection and comparator-input forwarding for early-resolved
// beq/bne branches, with a load-use stall FSM and a saturating stall counter.
module branch_hazard_forwarding_unit #(
  parameter int              ADDR_W  = 5,
  parameter int              NUM_SRC = 2,
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] BEQ_OP  = 6'b000100,
  parameter logic [OP_W-1:0] BNE_OP  = 6'b000101,
  parameter int              CNT_W   = 16
) (
  input logic                         clk,
  input logic                         reset,
  branch_hazard_forwarding_unit_if.slave bus
);

  typedef enum logic {IDLE, STALL} stateT;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stateT                state, stateNext;
  logic [1:0]           remaining, remainingNext;
  logic                 isBr;
  logic [NUM_SRC-1:0]   h2Port, h1Port, memFwdPort, wbFwdPort;
  logic                 hz1, hz2, stallInt;
  logic [2*NUM_SRC-1:0] fwdSelInt;
  logic [CNT_W-1:0]     stallCount;

  assign isBr = bus.idValid & ((bus.idOp == BEQ_OP) | (bus.idOp == BNE_OP));

  // Register 0 is hard-wired, so a zero source never matches a producer.
  always_comb begin
    logic [ADDR_W-1:0] src;
    logic exMatch, memMatch, wbMatch;
    src        = '0;
    exMatch    = 1'b0;
    memMatch   = 1'b0;
    wbMatch    = 1'b0;
    h2Port     = '0;
    h1Port     = '0;
    memFwdPort = '0;
    wbFwdPort  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src      = bus.idSrcRegs[i*ADDR_W +: ADDR_W];
      exMatch  = (src != '0) && bus.idexRegWrite && (src == bus.idexWriteReg);
      memMatch = (src != '0) && bus.exmeRegWrite && (src == bus.exmeWriteReg);
      wbMatch  = (src != '0) && bus.mewbRegWrite && (src == bus.mewbWriteReg);
      h2Port[i]     = exMatch && bus.idexMemRead;
      h1Port[i]     = (exMatch && !bus.idexMemRead) || (memMatch && bus.exmeMemRead);
      memFwdPort[i] = memMatch && !bus.exmeMemRead;
      wbFwdPort[i]  = wbMatch;
    end
  end

  assign hz2 = isBr & (|h2Port);
  assign hz1 = isBr & (|h1Port) & ~hz2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 2'd0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
    end
  end

  // A load in EX needs the IDLE hazard cycle plus one held STALL cycle.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    stallInt      = 1'b0;
    case (state)
      IDLE: begin
        stallInt = hz1 | hz2;
        if (hz2) begin
          stateNext     = STALL;
          remainingNext = 2'd1;
        end
      end
      STALL: begin
        stallInt      = 1'b1;
        remainingNext = remaining - 2'd1;
        if (remaining <= 2'd1) stateNext = IDLE;
      end
    endcase
  end

  // The newest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwdSelInt = '0;
    if (!stallInt && isBr) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (memFwdPort[i])     fwdSelInt[2*i +: 2] = 2'b01;
        else if (wbFwdPort[i]) fwdSelInt[2*i +: 2] = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCount <= '0;
    else if (stallInt && (stallCount != {CNT_W{1'b1}})) stallCount <= stallCount + CNT_ONE;
  end

  // Controls are forced to their run values while reset is asserted.
  assign bus.stall       = stallInt & ~reset;
  assign bus.idexFlush   = stallInt & ~reset;
  assign bus.pcWrite     = ~(stallInt & ~reset);
  assign bus.ifidWrite   = ~(stallInt & ~reset);
  assign bus.fwdSel      = reset ? '0 : fwdSelInt;
  assign bus.stallCycles = stallCount;

endmodule
